// File: rtl/immgen_pipe.sv
// Immediate generator with a two-entry skid buffer on its output.
// The immediate is computed when an item is accepted and the buffer holds the
// finished {imm, illegal, tag} record. in_ready is registered, so upstream
// never sees a combinational path from out_ready.
module immgen_pipe #(
  parameter int XLEN     = 32,
  parameter int AUTO_SEL = 0,
  parameter int TAG_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_imm_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] SEL_I   = 3'd0;
  localparam logic [2:0] SEL_S   = 3'd1;
  localparam logic [2:0] SEL_B   = 3'd2;
  localparam logic [2:0] SEL_U   = 3'd3;
  localparam logic [2:0] SEL_J   = 3'd4;
  localparam logic [2:0] SEL_Z   = 3'd5;
  localparam logic [2:0] SEL_BAD = 3'd7;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t            state_reg, state_next;
  logic              in_ready_reg;
  logic [XLEN-1:0]   out_imm_reg, skid_imm_reg;
  logic              out_illegal_reg, skid_illegal_reg;
  logic [TAG_W-1:0]  out_tag_reg, skid_tag_reg;

  logic [2:0]        fmt;
  logic [31:0]       imm32;
  logic              illegal;
  logic [XLEN-1:0]   imm_ext;
  logic              accept, pop;
  logic              load_out, load_skid, move_skid;

  assign accept = in_valid && in_ready_reg;
  assign pop    = out_valid && out_ready;

  // Pick the immediate format, either from the explicit select or by decoding the opcode.
  always_comb begin
    fmt = in_imm_sel;
    if (AUTO_SEL != 0) begin
      case (in_instr[6:0])
        7'b0010011, 7'b0000011, 7'b1100111: fmt = SEL_I;
        7'b0100011:                         fmt = SEL_S;
        7'b1100011:                         fmt = SEL_B;
        7'b0110111, 7'b0010111:             fmt = SEL_U;
        7'b1101111:                         fmt = SEL_J;
        7'b1110011:                         fmt = in_instr[14] ? SEL_Z : SEL_I;
        default:                            fmt = SEL_BAD;
      endcase
    end
  end

  // Assemble the 32-bit immediate; Z is zero-extended so its bit 31 is always 0.
  always_comb begin
    imm32   = 32'd0;
    illegal = 1'b0;
    case (fmt)
      SEL_I: imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      SEL_S: imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      SEL_B: imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                      in_instr[30:25], in_instr[11:8], 1'b0};
      SEL_U: imm32 = {in_instr[31:12], 12'd0};
      SEL_J: imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                      in_instr[20], in_instr[30:21], 1'b0};
      SEL_Z: imm32 = {27'd0, in_instr[19:15]};
      default: illegal = 1'b1;
    endcase
  end

  // Widening replicates bit 31, which is correct for both signed and Z formats.
  assign imm_ext = {{(XLEN-31){imm32[31]}}, imm32[30:0]};

  // Buffer control: decide the next occupancy and which register gets written.
  always_comb begin
    state_next = state_reg;
    load_out   = 1'b0;
    load_skid  = 1'b0;
    move_skid  = 1'b0;
    case (state_reg)
      EMPTY: begin
        if (accept) begin
          state_next = ONE;
          load_out   = 1'b1;
        end
      end
      ONE: begin
        if (accept && !pop) begin
          state_next = TWO;
          load_skid  = 1'b1;
        end else if (pop && !accept) begin
          state_next = EMPTY;
        end else if (accept && pop) begin
          load_out   = 1'b1;
        end
      end
      TWO: begin
        if (pop) begin
          state_next = ONE;
          move_skid  = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // Occupancy state and the registered ready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= EMPTY;
      in_ready_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      in_ready_reg <= (state_next != TWO);
    end
  end

  // Output and skid registers holding computed items.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_imm_reg      <= '0;
      out_illegal_reg  <= 1'b0;
      out_tag_reg      <= '0;
      skid_imm_reg     <= '0;
      skid_illegal_reg <= 1'b0;
      skid_tag_reg     <= '0;
    end else begin
      if (load_out) begin
        out_imm_reg     <= imm_ext;
        out_illegal_reg <= illegal;
        out_tag_reg     <= in_tag;
      end else if (move_skid) begin
        out_imm_reg     <= skid_imm_reg;
        out_illegal_reg <= skid_illegal_reg;
        out_tag_reg     <= skid_tag_reg;
      end
      if (load_skid) begin
        skid_imm_reg     <= imm_ext;
        skid_illegal_reg <= illegal;
        skid_tag_reg     <= in_tag;
      end
    end
  end

  assign in_ready    = in_ready_reg;
  assign out_valid   = (state_reg != EMPTY);
  assign out_imm     = out_imm_reg;
  assign out_illegal = out_illegal_reg;
  assign out_tag     = out_tag_reg;

endmodule

// File: tb/tb_immgen_pipe.sv
// Directed bench for immgen_pipe: a 32-bit explicit-select instance and a
// 64-bit opcode-decoding instance share stimulus; each has its own expectations.
module tb_immgen_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = 32'd0;
  logic [2:0]  in_imm_sel = 3'd0;
  logic [7:0]  in_tag = 8'd0;
  logic        out_ready = 1'b1;

  logic        a_in_ready, a_out_valid, a_out_illegal;
  logic [31:0] a_out_imm;
  logic [7:0]  a_out_tag;
  logic        b_in_ready, b_out_valid, b_out_illegal;
  logic [63:0] b_out_imm;
  logic [7:0]  b_out_tag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  immgen_pipe #(.XLEN(32), .AUTO_SEL(0), .TAG_W(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_imm_sel(in_imm_sel), .in_tag(in_tag),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_imm(a_out_imm),
    .out_illegal(a_out_illegal), .out_tag(a_out_tag)
  );

  immgen_pipe #(.XLEN(64), .AUTO_SEL(1), .TAG_W(8)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_imm_sel(in_imm_sel), .in_tag(in_tag),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_imm(b_out_imm),
    .out_illegal(b_out_illegal), .out_tag(b_out_tag)
  );

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  sel;
    logic [31:0] imm32;
    logic        ill32;
    logic [63:0] imm64;
    logic        ill64;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    logic [31:0] held_imm;

    vecs[0]  = '{32'hFFF00093, 3'b000, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vecs[1]  = '{32'h0020A423, 3'b001, 32'h00000008, 1'b0, 64'h0000000000000008, 1'b0};
    vecs[2]  = '{32'hFE000EE3, 3'b010, 32'hFFFFFFFC, 1'b0, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[3]  = '{32'h123450B7, 3'b011, 32'h12345000, 1'b0, 64'h0000000012345000, 1'b0};
    vecs[4]  = '{32'h001000EF, 3'b100, 32'h00000800, 1'b0, 64'h0000000000000800, 1'b0};
    vecs[5]  = '{32'h000FD073, 3'b101, 32'h0000001F, 1'b0, 64'h000000000000001F, 1'b0};
    vecs[6]  = '{32'h800000B7, 3'b011, 32'h80000000, 1'b0, 64'hFFFFFFFF80000000, 1'b0};
    vecs[7]  = '{32'hFFF00093, 3'b110, 32'h00000000, 1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vecs[8]  = '{32'h00000000, 3'b111, 32'h00000000, 1'b1, 64'h0000000000000000, 1'b1};
    vecs[9]  = '{32'h80002073, 3'b000, 32'hFFFFF800, 1'b0, 64'hFFFFFFFFFFFFF800, 1'b0};
    vecs[10] = '{32'h7FF00067, 3'b000, 32'h000007FF, 1'b0, 64'h00000000000007FF, 1'b0};

    // Reset state while rst_n is low.
    #1;
    chk("rst_out_valid", {63'd0, a_out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, a_in_ready}, 64'd0);
    chk("rst_out_imm", {32'd0, a_out_imm}, 64'd0);
    chk("rst_out_tag", {56'd0, a_out_tag}, 64'd0);
    chk("rst_out_illegal", {63'd0, a_out_illegal}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {63'd0, a_in_ready}, 64'd1);
    chk("ready64_after_rst", {63'd0, b_in_ready}, 64'd1);

    // Streaming table: one item per cycle, each result one cycle after accept.
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("v%0d_in_ready", i), {63'd0, a_in_ready}, 64'd1);
      in_valid   = 1'b1;
      in_instr   = vecs[i].instr;
      in_imm_sel = vecs[i].sel;
      in_tag     = 8'(i + 16);
      @(negedge clk);
      chk($sformatf("v%0d_valid32", i), {63'd0, a_out_valid}, 64'd1);
      chk($sformatf("v%0d_imm32", i), {32'd0, a_out_imm}, {32'd0, vecs[i].imm32});
      chk($sformatf("v%0d_ill32", i), {63'd0, a_out_illegal}, {63'd0, vecs[i].ill32});
      chk($sformatf("v%0d_tag32", i), {56'd0, a_out_tag}, 64'(i + 16));
      chk($sformatf("v%0d_imm64", i), b_out_imm, vecs[i].imm64);
      chk($sformatf("v%0d_ill64", i), {63'd0, b_out_illegal}, {63'd0, vecs[i].ill64});
      chk($sformatf("v%0d_tag64", i), {56'd0, b_out_tag}, 64'(i + 16));
      $display("vec %0d instr=0x%08h sel=%0d imm32=0x%08h imm64=0x%016h", i,
               vecs[i].instr, vecs[i].sel, a_out_imm, b_out_imm);
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("drained_valid", {63'd0, a_out_valid}, 64'd0);

    // Backpressure: tags 1,2,3 pushed back-to-back with out_ready low.
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    in_imm_sel = 3'b000;
    in_instr   = 32'h00100093;
    in_tag     = 8'd1;
    @(negedge clk);
    chk("bp_t1_valid", {63'd0, a_out_valid}, 64'd1);
    chk("bp_t1_tag", {56'd0, a_out_tag}, 64'd1);
    chk("bp_ready_one", {63'd0, a_in_ready}, 64'd1);
    held_imm = a_out_imm;
    chk("bp_t1_imm", {32'd0, a_out_imm}, 64'd1);
    in_instr = 32'h00200093;
    in_tag   = 8'd2;
    @(negedge clk);
    chk("bp_ready_two", {63'd0, a_in_ready}, 64'd0);
    chk("bp_hold_tag_a", {56'd0, a_out_tag}, 64'd1);
    in_instr = 32'h00300093;
    in_tag   = 8'd3;
    @(negedge clk);
    chk("bp_ready_still0", {63'd0, a_in_ready}, 64'd0);
    chk("bp_hold_tag_b", {56'd0, a_out_tag}, 64'd1);
    chk("bp_hold_imm", {32'd0, a_out_imm}, {32'd0, held_imm});
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_pop_tag2", {56'd0, a_out_tag}, 64'd2);
    chk("bp_pop_imm2", {32'd0, a_out_imm}, 64'd2);
    chk("bp_ready_back", {63'd0, a_in_ready}, 64'd1);
    @(negedge clk);
    chk("bp_pop_tag3", {56'd0, a_out_tag}, 64'd3);
    chk("bp_pop_imm3", {32'd0, a_out_imm}, 64'd3);
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_empty", {63'd0, a_out_valid}, 64'd0);
    $display("backpressure sequence done");

    // Fill both entries, then pulse reset between edges.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_tag    = 8'd7;
    @(negedge clk);
    in_tag = 8'd8;
    @(negedge clk);
    in_valid = 1'b0;
    chk("two_valid", {63'd0, a_out_valid}, 64'd1);
    chk("two_ready", {63'd0, a_in_ready}, 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {63'd0, a_out_valid}, 64'd0);
    chk("arst_ready", {63'd0, a_in_ready}, 64'd0);
    chk("arst_tag", {56'd0, a_out_tag}, 64'd0);
    chk("arst_imm", {32'd0, a_out_imm}, 64'd0);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {63'd0, a_in_ready}, 64'd1);
    chk("post_rst_valid0", {63'd0, a_out_valid}, 64'd0);
    @(negedge clk);
    chk("post_rst_valid1", {63'd0, a_out_valid}, 64'd0);
    in_valid   = 1'b1;
    in_instr   = 32'h000FD073;
    in_imm_sel = 3'b101;
    in_tag     = 8'd9;
    @(negedge clk);
    in_valid = 1'b0;
    chk("post_rst_new_valid", {63'd0, a_out_valid}, 64'd1);
    chk("post_rst_new_tag", {56'd0, a_out_tag}, 64'd9);
    chk("post_rst_new_imm", {32'd0, a_out_imm}, 64'h1F);
    @(negedge clk);
    chk("post_rst_no_dup", {63'd0, a_out_valid}, 64'd0);
    $display("reset sequence done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
